step_counter_limit_unit: RTL and testbench

- Decodes a quadrature encoder (A/B) into a signed 16-bit step count.
- Compares the count against a loadable 16-bit limit and raises `done` when the count equals the limit.
- Exposes count, limit and status as byte registers on the peripheral read bus.
- Sits between the encoder input pins and the CPU bus as a motion-step monitor.

---
 rtl/step_counter_limit_unit.sv | 127 ++++++++++++
 tb/tb_step_counter_limit_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/step_counter_limit_unit.sv
// Quadrature step counter: signed 16-bit count, loadable limit with registered done flag,
// byte-wide register read bus. Define STEP_COUNT_SNAPSHOT_EN for a coherent count MSB read.
module step_counter_limit_unit #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        cs,
  input  logic        rd,
  output logic [7:0]  data_out,
  input  logic        A,
  input  logic        B,
  input  logic [15:0] limit_in,
  input  logic        load_limit,
  output logic        done
);

  logic [SYNC_STAGES-1:0] r_a_sync, r_b_sync;
  logic [1:0]             r_prev_ab;
  logic [15:0]            r_count, r_limit;
  logic                   r_limit_valid, r_done, r_error, r_dir;
  logic [7:0]             r_data_out;

  logic [1:0]  w_ab;
  logic        w_step_up, w_step_dn, w_invalid;
  logic [15:0] w_count_nxt, w_limit_nxt;
  logic        w_limit_valid_nxt, w_error_nxt, w_dir_nxt, w_done_nxt;
  logic [15:0] w_offset;
  logic        w_rd;
  logic [7:0]  w_rdata;

`ifdef STEP_COUNT_SNAPSHOT_EN
  logic [7:0] r_shadow;
`endif

  assign w_ab      = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};
  assign w_step_up = (r_prev_ab == 2'b10) && (w_ab == 2'b00);
  assign w_step_dn = (r_prev_ab == 2'b01) && (w_ab == 2'b00);
  assign w_invalid = ((r_prev_ab ^ w_ab) == 2'b11);

  // A load restarts the move and takes priority over any step seen in the same cycle.
  always_comb begin
    w_count_nxt       = r_count;
    w_limit_nxt       = r_limit;
    w_limit_valid_nxt = r_limit_valid;
    w_error_nxt       = r_error | w_invalid;
    w_dir_nxt         = r_dir;
    if (w_step_up) begin
      w_count_nxt = r_count + 16'd1;
      w_dir_nxt   = 1'b1;
    end else if (w_step_dn) begin
      w_count_nxt = r_count - 16'd1;
      w_dir_nxt   = 1'b0;
    end
    if (load_limit) begin
      w_count_nxt       = 16'd0;
      w_limit_nxt       = limit_in;
      w_limit_valid_nxt = 1'b1;
      w_error_nxt       = 1'b0;
    end
    w_done_nxt = w_limit_valid_nxt && (w_count_nxt == w_limit_nxt);
  end

  assign w_offset = addr - BASE_ADDR;
  assign w_rd     = cs && rd;

  always_comb begin
    w_rdata = 8'h00;
    if (w_rd) begin
      case (w_offset)
        16'd0:   w_rdata = r_count[7:0];
`ifdef STEP_COUNT_SNAPSHOT_EN
        16'd1:   w_rdata = r_shadow;
`else
        16'd1:   w_rdata = r_count[15:8];
`endif
        16'd2:   w_rdata = r_limit[7:0];
        16'd3:   w_rdata = r_limit[15:8];
        16'd4:   w_rdata = {5'b0, r_error, r_dir, r_done};
        default: w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sync      <= '0;
      r_b_sync      <= '0;
      r_prev_ab     <= 2'b00;
      r_count       <= 16'd0;
      r_limit       <= 16'd0;
      r_limit_valid <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_dir         <= 1'b0;
      r_data_out    <= 8'h00;
    end else begin
      r_a_sync      <= {r_a_sync[SYNC_STAGES-2:0], A};
      r_b_sync      <= {r_b_sync[SYNC_STAGES-2:0], B};
      r_prev_ab     <= w_ab;
      r_count       <= w_count_nxt;
      r_limit       <= w_limit_nxt;
      r_limit_valid <= w_limit_valid_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_dir         <= w_dir_nxt;
      r_data_out    <= w_rdata;
    end
  end

`ifdef STEP_COUNT_SNAPSHOT_EN
  // Reading the LSB freezes the MSB so a two-byte read sees one consistent count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= 8'h00;
    end else if (w_rd && (w_offset == 16'd0)) begin
      r_shadow <= r_count[15:8];
    end
  end
`endif

  assign data_out = r_data_out;
  assign done     = r_done;

endmodule

// File: tb/tb_step_counter_limit_unit.sv
// Directed-vector bench for step_counter_limit_unit with hand-computed expectations.
module tb_step_counter_limit_unit;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        cs, rd;
  logic [7:0]  data_out;
  logic        A, B;
  logic [15:0] limit_in;
  logic        load_limit;
  logic        done;

  int checks   = 0;
  int failures = 0;

  step_counter_limit_unit #(
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(SYNC)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .cs        (cs),
    .rd        (rd),
    .data_out  (data_out),
    .A         (A),
    .B         (B),
    .limit_in  (limit_in),
    .load_limit(load_limit),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic a, input logic b);
    A = a;
    B = b;
    tick(SYNC + 1);
  endtask

  task automatic cw_cycle();
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b1);
    set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b0);
  endtask

  task automatic ccw_cycle();
    set_ab(1'b1, 1'b0);
    set_ab(1'b1, 1'b1);
    set_ab(1'b0, 1'b1);
    set_ab(1'b0, 1'b0);
  endtask

  task automatic load(input logic [15:0] val);
    limit_in   = val;
    load_limit = 1'b1;
    tick(1);
    load_limit = 1'b0;
  endtask

  task automatic read_raw(input logic [15:0] a, output logic [7:0] d);
    addr = a;
    cs   = 1'b1;
    rd   = 1'b1;
    tick(1);
    cs   = 1'b0;
    rd   = 1'b0;
    d    = data_out;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] off, input logic [7:0] exp);
    logic [7:0] d;
    read_raw(BASE + off, d);
    check_eq(tag, {8'h00, d}, {8'h00, exp});
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0; addr = '0; cs = 1'b0; rd = 1'b0;
    A = 1'b0; B = 1'b0; limit_in = '0; load_limit = 1'b0;
    tick(5);
    rst_n = 1'b1;
    check_eq("rst_done", {15'd0, done}, 16'd0);
    for (int i = 0; i < 5; i++) read_chk($sformatf("rst_reg%0d", i), i[15:0], 8'h00);

    load(16'd5);
    check_eq("load5_done", {15'd0, done}, 16'd0);
    repeat (5) cw_cycle();
    check_eq("cw5_done_pin", {15'd0, done}, 16'd1);
    read_chk("cw5_cnt_lo", 16'd0, 8'h05);
    read_chk("cw5_cnt_hi", 16'd1, 8'h00);
    read_chk("cw5_lim_lo", 16'd2, 8'h05);
    read_chk("cw5_lim_hi", 16'd3, 8'h00);
    read_chk("cw5_status", 16'd4, 8'h03);
    tick(1);
    check_eq("idle_dout", {8'h00, data_out}, 16'h0000);
    read_chk("addr_off5", 16'd5, 8'h00);
    read_chk("addr_alias", 16'h0100, 8'h00);
    addr = BASE; cs = 1'b1; rd = 1'b0;
    tick(1);
    cs = 1'b0;
    check_eq("cs_no_rd", {8'h00, data_out}, 16'h0000);

    repeat (2) ccw_cycle();
    check_eq("ccw2_done_pin", {15'd0, done}, 16'd0);
    read_chk("ccw2_cnt_lo", 16'd0, 8'h03);
    read_chk("ccw2_cnt_hi", 16'd1, 8'h00);
    read_chk("ccw2_status", 16'd4, 8'h00);

    load(16'hFFFF);
    ccw_cycle();
    check_eq("wrap_dn_done", {15'd0, done}, 16'd1);
    read_chk("wrap_dn_lo", 16'd0, 8'hFF);
    read_chk("wrap_dn_hi", 16'd1, 8'hFF);
    read_chk("wrap_dn_status", 16'd4, 8'h01);
    cw_cycle();
    check_eq("wrap_up_done", {15'd0, done}, 16'd0);
    read_chk("wrap_up_lo", 16'd0, 8'h00);
    read_chk("wrap_up_hi", 16'd1, 8'h00);

    set_ab(1'b1, 1'b1);
    set_ab(1'b0, 1'b0);
    read_chk("inv_status", 16'd4, 8'h06);
    read_chk("inv_cnt_lo", 16'd0, 8'h00);
    read_chk("inv_cnt_hi", 16'd1, 8'h00);
    load(16'd3);
    read_chk("inv_cleared", 16'd4, 8'h02);

    cw_cycle();
    read_chk("pre_coll_lo", 16'd0, 8'h01);
    set_ab(1'b1, 1'b0);
    A = 1'b0; B = 1'b0;
    tick(SYNC);
    // The 10->00 step reaches the decoder on the very edge that samples this load.
    limit_in   = 16'd7;
    load_limit = 1'b1;
    tick(1);
    load_limit = 1'b0;
    tick(SYNC + 1);
    read_chk("coll_cnt_lo", 16'd0, 8'h00);
    read_chk("coll_cnt_hi", 16'd1, 8'h00);
    read_chk("coll_lim_lo", 16'd2, 8'h07);
    check_eq("coll_done", {15'd0, done}, 16'd0);

    load(16'd0);
    check_eq("load0_done", {15'd0, done}, 16'd1);

    load(16'hFFFF);
    ccw_cycle();
    read_chk("snap_lo", 16'd0, 8'hFF);
    cw_cycle();
`ifdef STEP_COUNT_SNAPSHOT_EN
    read_chk("snap_hi", 16'd1, 8'hFF);
`else
    read_chk("live_hi", 16'd1, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
